a0_trace_buffer: RTL

//  Downstream observer of the CPU top-level a0 output. Detects every change of a0,

---
 rtl/a0_trace_buffer_pkg.sv | 19 +
 rtl/a0_trace_buffer_if.sv | 21 ++
 rtl/a0_trace_buffer_sync_fifo.sv | 58 +++++
 rtl/a0_trace_buffer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/a0_trace_buffer_pkg.sv
// Shared types and default constants for the a0 trace buffer and its FIFO.
// A0_TIMESTAMP_EN selects whether entries carry a capture timestamp.
package trace_pkg;

    localparam int TRACE_DEPTH  = 16;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_TS_W   = 32;

    typedef enum logic [0:0] {
        CAP_IDLE,
        CAP_TRACK
    } cap_state_t;

    typedef struct packed {
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_TS_W-1:0]   ts;
    } trace_entry_t;

endpackage

// File: rtl/a0_trace_buffer_if.sv
// Valid/ready drain port of the a0 trace buffer.
// out_ts exists only when A0_TIMESTAMP_EN is defined.
interface a0_trace_buffer_if #(
    parameter int DATA_W = 32
`ifdef A0_TIMESTAMP_EN
   ,parameter int TS_W   = 32
`endif
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef A0_TIMESTAMP_EN
    logic [TS_W-1:0]   out_ts;

    modport master (output out_valid, output out_data, output out_ts, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ts, output out_ready);
`else
    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
`endif
endinterface

// File: rtl/a0_trace_buffer_sync_fifo.sv
// Generic synchronous FIFO; a push is accepted when not full or when popping.
// When empty, dout keeps presenting the most recently popped entry.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_hold;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_pop;
    logic             w_push_ok;

    assign o_level   = r_level;
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_pop     = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop);
    assign o_dout    = o_empty ? r_hold : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_hold   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/a0_trace_buffer.sv
// Captures every change of the CPU a0 value into a FIFO drained over valid/ready.
// Define A0_TIMESTAMP_EN to tag each entry with a free-running cycle count.
module a0_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int DATA_W = 32
`ifdef A0_TIMESTAMP_EN
   ,parameter int TS_W   = TRACE_TS_W
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DATA_W-1:0]      a0,
    input  logic                   clr_ovf,
    a0_trace_buffer_if.master      out_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    // state     | meaning
    // CAP_IDLE  | no reference value held; next enabled cycle captures a0
    // CAP_TRACK | last_a0 valid; capture only when a0 differs from it
`ifdef A0_TIMESTAMP_EN
    localparam int ENTRY_W = DATA_W + TS_W;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    cap_state_t         r_state;
    cap_state_t         w_state_nxt;
    logic [DATA_W-1:0]  r_last_a0;
    logic               r_overflow;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            CAP_IDLE: begin
                if (en) begin
                    w_push      = 1'b1;
                    w_state_nxt = CAP_TRACK;
                end
            end
            CAP_TRACK: begin
                w_push = en && (a0 != r_last_a0);
            end
            default: w_state_nxt = CAP_IDLE;
        endcase
    end

    // last_a0 follows every detected change, including ones the FIFO drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CAP_IDLE;
            r_last_a0 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_last_a0 <= a0;
            end
        end
    end

    assign w_pop  = out_if.out_valid && out_if.out_ready;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef A0_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_din         = {a0, r_ts};
    assign out_if.out_ts = w_dout[TS_W-1:0];
`else
    assign w_din = a0;
`endif

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_if.out_valid = !w_empty;
    assign out_if.out_data  = w_dout[ENTRY_W-1 -: DATA_W];
    assign overflow         = r_overflow;

endmodule
